// File: rtl/food_spawn_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// food_spawn_ctrl
//
// Places food for the snake game. A spawn request makes the block pulse the
// random-position generator, latch the candidate it returns, and scan the
// snake body memory for a collision. A colliding candidate is retried until
// MAX_TRY candidates have been drawn. After that, the last candidate is
// committed with spawn_fail flagged so the game FSM can decide what to do.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   spawn_req   one-cycle request for new food (ignored while busy)
//   snake_len   number of valid body segments, sampled on request accept
//   rand_drive  one-cycle pulse to the random-position generator
//   rand_x/y    candidate position, valid GEN_LAT cycles after rand_drive
//   seg_idx     body memory read address (0 outside the scan)
//   seg_x/y     body segment data, one cycle after seg_idx
//   food_x/y    committed food position
//   food_valid  committed position is on the board
//   spawn_done  one-cycle pulse on commit
//   spawn_fail  one-cycle pulse with spawn_done when every candidate collided
//   busy        high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module food_spawn_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int MAX_TRY = 8,
    parameter int GEN_LAT = 1,
    parameter int DATA_W  = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spawn_req,
    input  logic [$clog2(MAX_LEN):0]   snake_len,
    output logic                       rand_drive,
    input  logic [DATA_W-1:0]          rand_x,
    input  logic [DATA_W-1:0]          rand_y,
    output logic [$clog2(MAX_LEN)-1:0] seg_idx,
    input  logic [DATA_W-1:0]          seg_x,
    input  logic [DATA_W-1:0]          seg_y,
    output logic [DATA_W-1:0]          food_x,
    output logic [DATA_W-1:0]          food_y,
    output logic                       food_valid,
    output logic                       spawn_done,
    output logic                       spawn_fail,
    output logic                       busy
);

    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int LEN_W  = IDX_W + 1;
    localparam int TRY_W  = $clog2(MAX_TRY + 1);
    localparam int WAIT_W = $clog2(GEN_LAT + 1);

    localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [TRY_W-1:0]  MAX_TRY_V = TRY_W'(MAX_TRY);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GEN_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_WAIT,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t state, state_nxt;

    // Control registers
    logic [LEN_W-1:0]  len_q;
    logic [TRY_W-1:0]  try_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [LEN_W-1:0]  scan_cnt;

    // Candidate position (pure data, no reset needed)
    logic [DATA_W-1:0] cand_x;
    logic [DATA_W-1:0] cand_y;

    // Next values of the registered outputs and counters
    logic              rand_drive_d;
    logic [IDX_W-1:0]  seg_idx_d;
    logic              food_valid_d;
    logic              spawn_done_d;
    logic              spawn_fail_d;
    logic              busy_d;
    logic [LEN_W-1:0]  scan_cnt_d;

    logic accept;
    logic hit;
    logic tries_left;

    // Body lengths beyond the memory depth are clamped to the full body.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
        return (req > MAX_LEN_V) ? MAX_LEN_V : req;
    endfunction

    assign accept     = (state == S_IDLE) && spawn_req;
    assign tries_left = (try_cnt < MAX_TRY_V);

    // scan_cnt == 0 is the cycle the first address is presented; memory data
    // for address scan_cnt-1 arrives in every later scan cycle.
    assign hit = (state == S_SCAN) && (scan_cnt != '0) &&
                 (seg_x == cand_x) && (seg_y == cand_y);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (spawn_req) state_nxt = S_GEN;
            end
            S_GEN: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (hit) begin
                    state_nxt = tries_left ? S_GEN : S_COMMIT;
                end else if (scan_cnt == len_q) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: every output is registered, so this computes the value
    // each output takes in the cycle the FSM enters state_nxt.
    // -----------------------------------------------------------------------
    always_comb begin
        rand_drive_d = (state_nxt == S_GEN);
        busy_d       = (state_nxt != S_IDLE);
        spawn_done_d = (state_nxt == S_COMMIT);
        // Only a hit with the budget exhausted reaches COMMIT as a failure.
        spawn_fail_d = hit && !tries_left;

        scan_cnt_d = '0;
        if (state_nxt == S_SCAN) begin
            scan_cnt_d = (state == S_SCAN) ? (scan_cnt + LEN_W'(1)) : '0;
        end

        // Addresses 0..len-1 only; the final scan cycle just waits for the
        // last segment's data, so the address returns to 0 there.
        seg_idx_d = '0;
        if ((state_nxt == S_SCAN) && (scan_cnt_d < len_q)) begin
            seg_idx_d = scan_cnt_d[IDX_W-1:0];
        end

        food_valid_d = food_valid;
        if (accept) begin
            food_valid_d = 1'b0;
        end else if (state_nxt == S_COMMIT) begin
            food_valid_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            try_cnt    <= '0;
            wait_cnt   <= '0;
            scan_cnt   <= '0;
            rand_drive <= 1'b0;
            seg_idx    <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (accept) begin
                len_q   <= clamp_len(snake_len);
                try_cnt <= '0;
            end else if (state == S_GEN) begin
                try_cnt <= try_cnt + TRY_W'(1);
            end

            if (state == S_GEN) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            scan_cnt   <= scan_cnt_d;
            rand_drive <= rand_drive_d;
            seg_idx    <= seg_idx_d;
            food_valid <= food_valid_d;
            spawn_done <= spawn_done_d;
            spawn_fail <= spawn_fail_d;
            busy       <= busy_d;

            if (state_nxt == S_COMMIT) begin
                food_x <= cand_x;
                food_y <= cand_y;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Candidate register: captured at the end of the last WAIT cycle, when
    // the generator output has settled.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((state == S_WAIT) && (wait_cnt == WAIT_LAST)) begin
            cand_x <= rand_x;
            cand_y <= rand_y;
        end
    end

    // Structural invariants of the registered outputs
    a_fail_with_done: assert property (@(posedge clk) disable iff (!rst_n)
        spawn_fail |-> spawn_done);
    a_drive_not_done: assert property (@(posedge clk) disable iff (!rst_n)
        !(rand_drive && spawn_done));
    a_idx_scan_only: assert property (@(posedge clk) disable iff (!rst_n)
        (seg_idx != '0) |-> (state == S_SCAN));

endmodule

// File: tb/tb_food_spawn_ctrl.sv
`timescale 1ns/1ps
module tb_food_spawn_ctrl;

    logic       clk;
    logic       rst_n;
    logic       spawn_req;
    logic [6:0] snake_len;
    logic       rand_drive;
    logic [9:0] rand_x, rand_y;
    logic [5:0] seg_idx;
    logic [9:0] seg_x, seg_y;
    logic [9:0] food_x, food_y;
    logic       food_valid, spawn_done, spawn_fail, busy;

    food_spawn_ctrl #(.MAX_LEN(64), .MAX_TRY(8), .GEN_LAT(1), .DATA_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .snake_len(snake_len),
        .rand_drive(rand_drive), .rand_x(rand_x), .rand_y(rand_y),
        .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .spawn_done(spawn_done), .spawn_fail(spawn_fail), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator stub: first candidate until the second rand_drive, then the second.
    int stub_n = 0;
    int stub_base = 0;
    logic [9:0] c0x, c0y, c1x, c1y;
    always @(posedge clk) if (rand_drive) stub_n <= stub_n + 1;
    always_comb begin
        if (stub_n - stub_base <= 1) begin
            rand_x = c0x; rand_y = c0y;
        end else begin
            rand_x = c1x; rand_y = c1y;
        end
    end

    // Body memory with registered read.
    logic [9:0] body_x [64];
    logic [9:0] body_y [64];
    always @(posedge clk) begin
        seg_x <= body_x[seg_idx];
        seg_y <= body_y[seg_idx];
    end

    typedef struct {
        int len;
        int c0x, c0y, c1x, c1y;
        int exp_done;      // -1: only require that it happens
        int exp_drives;
        int exp_fx, exp_fy, exp_fail;
        int exp_max_idx;
        int abort_before;  // 0: no requirement on second rand_drive cycle
    } vec_t;

    int checks = 0;
    int failures = 0;

    int r_done, r_drives, r_first, r_second, r_max_idx, r_busy1, r_fv1;
    int r_fx, r_fy, r_fail, r_fv_done, r_done_cnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rand_drive"}, int'(rand_drive), 0);
        chk({tag, "_seg_idx"},    int'(seg_idx), 0);
        chk({tag, "_food_x"},     int'(food_x), 0);
        chk({tag, "_food_y"},     int'(food_y), 0);
        chk({tag, "_flags"},      int'({food_valid, spawn_done, spawn_fail, busy}), 0);
    endtask

    // Issues a request in cycle 0 and observes cycles 1..budget until spawn_done.
    task automatic run_req(input int len, input int poke, input int budget);
        stub_base = stub_n;
        @(negedge clk);
        spawn_req = 1'b1;
        snake_len = 7'(len);
        r_done = -1; r_drives = 0; r_first = -1; r_second = -1; r_max_idx = 0;
        r_done_cnt = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            spawn_req = (n == poke);
            if (n == 1) begin
                r_busy1 = int'(busy);
                r_fv1   = int'(food_valid);
                snake_len = 7'd5;   // must not affect the accepted request
            end
            if (rand_drive) begin
                r_drives++;
                if (r_first < 0) r_first = n;
                else if (r_second < 0) r_second = n;
            end
            if (int'(seg_idx) > r_max_idx) r_max_idx = int'(seg_idx);
            if (spawn_done) begin
                r_done = n; r_done_cnt++;
                r_fx = int'(food_x); r_fy = int'(food_y);
                r_fail = int'(spawn_fail); r_fv_done = int'(food_valid);
                break;
            end
        end
        spawn_req = 1'b0;
    endtask

    task automatic set_stub(input vec_t v);
        c0x = 10'(v.c0x); c0y = 10'(v.c0y);
        c1x = 10'(v.c1x); c1y = 10'(v.c1y);
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        chk({tag, "_done_seen"}, int'(r_done > 0), 1);
        chk({tag, "_first_drive"}, r_first, 1);
        chk({tag, "_busy_c1"}, r_busy1, 1);
        chk({tag, "_fv_c1"}, r_fv1, 0);
        if (v.exp_done >= 0) chk({tag, "_done_cycle"}, r_done, v.exp_done);
        chk({tag, "_drives"}, r_drives, v.exp_drives);
        chk({tag, "_food_x"}, r_fx, v.exp_fx);
        chk({tag, "_food_y"}, r_fy, v.exp_fy);
        chk({tag, "_fail"}, r_fail, v.exp_fail);
        chk({tag, "_fv_done"}, r_fv_done, 1);
        chk({tag, "_max_idx"}, r_max_idx, v.exp_max_idx);
        if (v.abort_before > 0)
            chk({tag, "_abort"}, int'(r_second > 0 && r_second < v.abort_before), 1);
    endtask

    vec_t vecs[6];
    int extra_done;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3, 100, 200, 100, 200,  7, 1, 100, 200, 0,  2, 0};
        vecs[1] = '{3,  20,  10,  50,  60, -1, 2,  50,  60, 0,  2, 7};
        vecs[2] = '{1,  10,  10,  10,  10, -1, 8,  10,  10, 1,  0, 0};
        vecs[3] = '{0, 300, 400, 300, 400,  4, 1, 300, 400, 0,  0, 0};
        vecs[4] = '{100, 100, 200, 100, 200, 68, 1, 100, 200, 0, 63, 0};
        vecs[5] = '{2,  30,  10,  30,  10,  6, 1,  30,  10, 0,  1, 0};

        for (int i = 0; i < 64; i++) begin
            body_x[i] = 10'(600 + i);
            body_y[i] = 10'd900;
        end
        body_x[0] = 10'd10; body_y[0] = 10'd10;
        body_x[1] = 10'd20; body_y[1] = 10'd10;
        body_x[2] = 10'd30; body_y[2] = 10'd10;

        rst_n = 1'b0; spawn_req = 1'b0; snake_len = 7'd0;
        set_stub(vecs[0]);
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            set_stub(vecs[i]);
            run_req(vecs[i].len, 0, 200);
            check_vec(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_busy_after", i), int'(busy), 0);
        end

        // Request pulsed while busy is ignored: one commit at the normal time.
        set_stub(vecs[0]);
        run_req(3, 3, 200);
        chk("poke_done_cycle", r_done, 7);
        extra_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (spawn_done) extra_done++;
        end
        chk("poke_extra_done", extra_done, 0);
        chk("poke_idle", int'(busy), 0);

        // Back-to-back: new request in the cycle right after spawn_done.
        run_req(3, 0, 200);
        chk("b2b_first_done", r_done, 7);
        run_req(3, 0, 200);
        chk("b2b_fv_drop", r_fv1, 0);
        chk("b2b_busy_c1", r_busy1, 1);
        chk("b2b_second_done", r_done, 7);
        @(negedge clk);

        // Reset asserted in the middle of a long scan.
        @(negedge clk);
        spawn_req = 1'b1; snake_len = 7'd64;
        @(negedge clk);
        spawn_req = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        chk("mid_seg_idx", int'(seg_idx), 7);
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (spawn_done) extra_done++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (spawn_done || busy) extra_done++;
        end
        chk("reset_no_done", extra_done, 0);

        // Recovery after reset.
        run_req(3, 0, 200);
        check_vec(vecs[0], "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
